// File: rtl/pic_inta_sequencer.sv
// Two-pulse 8086-style INTA sequencer between pic8259 and the CPU core.
// Captures the vector on the second pulse and offers it over valid/ready.
module pic_inta_sequencer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned PULSE_CYCLES    = 1,
  parameter int unsigned GAP_CYCLES      = 1,
  parameter int unsigned RECOVER_CYCLES  = 2,
  parameter logic [7:0]  SPURIOUS_VECTOR = 8'h07
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       interrupt_to_cpu,
  input  logic       cpu_int_enable,
  output logic       interrupt_acknowledge_n,
  input  logic [7:0] data_bus_out,
  input  logic       data_bus_io,
  output logic       vector_valid,
  output logic [7:0] vector,
  output logic       vector_spurious,
  input  logic       vector_ready,
  output logic       busy
);

  localparam int unsigned MAX_PG  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_PG > RECOVER_CYCLES) ? MAX_PG : RECOVER_CYCLES;
  localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] PULSE_LOAD   = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD     = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] RECOVER_LOAD = CW'(RECOVER_CYCLES - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] INTA1   = 3'd1;
  localparam logic [2:0] GAP     = 3'd2;
  localparam logic [2:0] INTA2   = 3'd3;
  localparam logic [2:0] HOLD    = 3'd4;
  localparam logic [2:0] RECOVER = 3'd5;

  logic [2:0]             state;
  logic [CW-1:0]          count;
  logic [SYNC_STAGES-1:0] sync;
  logic                   int_s;

  assign int_s = sync[SYNC_STAGES-1];
  assign busy  = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync[0] <= interrupt_to_cpu;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  end

  // Each timed state loads count on entry and leaves when it reaches zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                   <= IDLE;
      count                   <= '0;
      interrupt_acknowledge_n <= 1'b1;
      vector_valid            <= 1'b0;
      vector                  <= '0;
      vector_spurious         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (int_s && cpu_int_enable) begin
            state                   <= INTA1;
            count                   <= PULSE_LOAD;
            interrupt_acknowledge_n <= 1'b0;
          end
        end
        INTA1: begin
          if (count == '0) begin
            state                   <= GAP;
            count                   <= GAP_LOAD;
            interrupt_acknowledge_n <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
        GAP: begin
          if (count == '0) begin
            state                   <= INTA2;
            count                   <= PULSE_LOAD;
            interrupt_acknowledge_n <= 1'b0;
          end else begin
            count <= count - 1'b1;
          end
        end
        INTA2: begin
          if (count == '0) begin
            state                   <= HOLD;
            interrupt_acknowledge_n <= 1'b1;
            vector_valid            <= 1'b1;
            if (!data_bus_io) begin
              vector          <= data_bus_out;
              vector_spurious <= 1'b0;
            end else begin
              vector          <= SPURIOUS_VECTOR;
              vector_spurious <= 1'b1;
            end
          end else begin
            count <= count - 1'b1;
          end
        end
        HOLD: begin
          if (vector_ready) begin
            state        <= RECOVER;
            count        <= RECOVER_LOAD;
            vector_valid <= 1'b0;
          end
        end
        RECOVER: begin
          if (count == '0) state <= IDLE;
          else             count <= count - 1'b1;
        end
        default: begin
          state                   <= IDLE;
          interrupt_acknowledge_n <= 1'b1;
          vector_valid            <= 1'b0;
        end
      endcase
    end
  end

endmodule
